// File: rtl/shift_add_mul32.sv
// shift_add_mul32: iterative 32x32 unsigned multiplier (radix-2 shift/add).
// It owns no adder. It drives the shared FullAdder32 through the Add* ports
// and folds the 33-bit sum back into the product register each RUN cycle.
// The 64-bit product is ready 32 cycles after an accepted Start.
module shift_add_mul32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic [63:0] Product,
    output logic [31:0] AddIn1,
    output logic [31:0] AddIn2,
    output logic        AddCI,
    input  logic [31:0] AddOut,
    input  logic        AddCO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] m;      // latched multiplicand
    logic [63:0] p;      // upper half: partial sum, lower half: remaining multiplier bits
    logic [4:0]  cnt;    // iteration counter, 0..31
    logic        load;   // accept new operands this cycle
    logic        step;   // perform one add/shift this cycle

    // Next-state, operand acceptance and adder operand drive.
    always_comb begin
        // NOTE: every output of this block gets a default first. This keeps
        // each one driven on every path through the case, so no latch is inferred.
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        AddIn1     = 32'h0;
        AddIn2     = 32'h0;
        AddCI      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Add the multiplicand when the current multiplier bit is set.
                AddIn1 = p[63:32];
                AddIn2 = p[0] ? m : 32'h0;
                step   = 1'b1;
                if (cnt == 5'd31) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A Start here chains the next multiply without an idle cycle.
                if (Start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register. Reset aborts any multiply in flight.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples pre-edge values, whatever order the blocks run in.
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: operand capture, then one add/shift per RUN cycle.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the datapath registers are reset too. A reset mid-RUN must make
        // Product read 0 straight away, not show the stale partial product.
        if (RST) begin
            m   <= 32'h0;
            p   <= 64'h0;
            cnt <= 5'd0;
        end else if (load) begin
            m   <= A;
            p   <= {32'h0, B};
            cnt <= 5'd0;
        end else if (step) begin
            // The 33-bit sum {carry, out} shifts right into P[63:31]. The
            // consumed multiplier bit P[0] drops off the bottom, so no carry is lost.
            p   <= {AddCO, AddOut, p[31:1]};
            cnt <= cnt + 5'd1;
        end
    end

    assign Busy    = (state == S_RUN);
    assign Done    = (state == S_DONE);
    assign Product = p;

endmodule

// File: tb/tb_shift_add_mul32.sv
// tb_shift_add_mul32: self-checking bench for shift_add_mul32.
// An ideal 33-bit adder stands in for FullAdder32 between the Add* ports.
// A transaction-level model predicts Busy, Done and the final product.
// A compare process checks the DUT against the model on every falling edge.
// Directed tests pin the model with hand-computed products.
module tb_shift_add_mul32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_in1;
    logic [31:0] add_in2;
    logic        add_ci;
    logic [31:0] add_out;
    logic        add_co;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    shift_add_mul32 dut (
        .CLK    (clk),
        .RST    (rst),
        .Start  (start),
        .A      (a),
        .B      (b),
        .Busy   (busy),
        .Done   (done),
        .Product(product),
        .AddIn1 (add_in1),
        .AddIn2 (add_in2),
        .AddCI  (add_ci),
        .AddOut (add_out),
        .AddCO  (add_co)
    );

    // Ideal stand-in for FullAdder32.
    assign {add_co, add_out} = {1'b0, add_in1} + {1'b0, add_in2} + {32'h0, add_ci};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model. An accepted request fixes the product as A*B.
    // The request keeps the unit busy for 32 cycles, then Done shows for one cycle.
    int          m_left;
    logic        m_done;
    logic [63:0] m_pending;
    logic [63:0] m_final;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left    <= 0;
            m_done    <= 1'b0;
            m_pending <= 64'h0;
            m_final   <= 64'h0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done  <= 1'b1;
                m_final <= m_pending;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left    <= 32;
                m_pending <= {32'h0, a} * {32'h0, b};
            end
        end
    end

    // Compare process. Product is only meaningful outside RUN.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_left != 0));
            check("done", done, m_done);
            check("add_ci", add_ci, 1'b0);
            if (m_left == 0) begin
                check("product", product, m_final);
                check("add_in1_idle", add_in1, 32'h0);
                check("add_in2_idle", add_in2, 32'h0);
            end
        end
    end

    // Waits for Done at falling edges within a cycle budget and counts Busy cycles.
    task automatic wait_done(input string name, output int busy_cycles);
        bit found = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (done) begin
                found = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, found, 1'b1);
    endtask

    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp);
        int bc;
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(name, bc);
        check({name, "_busy_cycles"}, bc, 32);
        check({name, "_product"}, product, exp);
    endtask

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        #23;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 64'h0);
        check("rst_add_in1", add_in1, 32'h0);
        check("rst_add_in2", add_in2, 32'h0);
        check("rst_add_ci", add_ci, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        run_op("mul_3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mul_zero", 32'h0, 32'h1234_5678, 64'h0);
        run_op("mul_one", 32'h1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF);

        // Product holds in IDLE until the next accepted Start.
        repeat (3) @(negedge clk);
        check("idle_hold", product, 64'h0000_0000_DEAD_BEEF);

        // A Start during RUN is ignored.
        @(negedge clk);
        a = 32'd7;
        b = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", bc);
        check("ignore_product", product, 64'd63);

        // Start held high: back-to-back multiplies, 32 cycles apart.
        @(negedge clk);
        a = 32'd2;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        wait_done("held0", bc);
        check("held0_busy_cycles", bc, 32);
        check("held0_product", product, 64'd6);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            wait_done("held", bc);
            check("held_busy_cycles", bc, 32);
            check("held_product", product, 64'd6);
            check("held_no_busy_in_done", busy, 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        check("held_stop_idle", busy, 1'b0);

        // Asynchronous reset at RUN cycle 10.
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        b = 32'h8000_0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_product", product, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mul_4x4", 32'd4, 32'd4, 64'd16);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
